// File: rtl/ula_vram_if.sv
// Bus bundle between ula_vram_port, its requesters (ULA fetch, CPU decoder) and the VRAM.
// slave: the port block itself. master: the ULA/CPU/VRAM side that surrounds it.
// Signals: ULA fetch (vreq/vaddr/vid_bank -> vdata/vvalid), CPU access (cpu_* req/ack),
// single-port synchronous VRAM (mem_addr/mem_we/mem_wdata -> mem_rdata one cycle later).
interface ula_vram_if #(
   parameter int AW = 13
);
   logic          vreq;
   logic [AW-1:0] vaddr;
   logic          vid_bank;
   logic [7:0]    vdata;
   logic          vvalid;

   logic          cpu_req;
   logic          cpu_we;
   logic          cpu_bank;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic [7:0]    cpu_rdata;
   logic          cpu_ack;

   logic [AW:0]   mem_addr;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   modport slave (
      input  vreq, vaddr, vid_bank, cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_wdata, mem_rdata,
      output vdata, vvalid, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vreq, vaddr, vid_bank, cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_wdata, mem_rdata,
      input  vdata, vvalid, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/ula_vram_port.sv
// Screen-memory responder: ULA fetches served from one single-port VRAM at fixed latency 2,
// CPU writes buffered in a small FIFO drained in idle cycles, CPU reads wait for an empty FIFO.
// Latency: ULA vreq -> vvalid/vdata exactly 2 cycles, never stalls. CPU write ack 1 cycle after push.
// Backpressure: a CPU write is held (no ack) while the FIFO is full; reads are held until it drains.
// Ports: clock, reset (async, active-high), bus (ula_vram_if.slave: ULA, CPU and VRAM signals).
// Option: define VRAM_SNOOP_EN to let ULA fetches see queued CPU writes (newest matching entry wins).
module ula_vram_port #(
   parameter int WFIFO_DEPTH = 4,
   parameter int AW          = 13
) (
   input  logic        clock,
   input  logic        reset,
   ula_vram_if.slave   bus
);
   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int EW = AW + 1 + 8;   // {bank, addr, data}

   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} rd_state_t;

   rd_state_t     state;
   logic [EW-1:0] fifo_mem [WFIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [AW:0]   rd_addr;
   logic          v_p1;

   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          rd_go;
   logic [EW-1:0] head;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (PW+1)'(WFIFO_DEPTH));
   // cpu_ack high means the request still on the bus was already taken last cycle.
   assign push  = bus.cpu_req & bus.cpu_we & ~fifo_full & ~bus.cpu_ack;
   assign rd_go = (state == RD_ISSUE) & ~bus.vreq;
   assign pop   = ~fifo_empty & ~bus.vreq & (state != RD_ISSUE);
   assign head  = fifo_mem[rd_ptr];

   // VRAM arbiter: ULA, then CPU read issue, then FIFO drain.
   always_comb begin
      bus.mem_addr  = head[EW-1:8];
      bus.mem_wdata = head[7:0];
      bus.mem_we    = 1'b0;
      if (bus.vreq) begin
         bus.mem_addr = {bus.vid_bank, bus.vaddr};
      end else if (rd_go) begin
         bus.mem_addr = rd_addr;
      end else if (pop) begin
         bus.mem_we = 1'b1;
      end
   end

`ifdef VRAM_SNOOP_EN
   logic          snoop_hit;
   logic [7:0]    snoop_dat;
   logic          snoop_hit_q;
   logic [7:0]    snoop_dat_q;
   logic [PW-1:0] snoop_idx;

   // Walk entries oldest to newest so the last hit is the newest write.
   always_comb begin
      snoop_hit = 1'b0;
      snoop_dat = 8'h00;
      snoop_idx = '0;
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
         snoop_idx = rd_ptr + PW'(i);
         if (((PW+1)'(i) < count) &&
             (fifo_mem[snoop_idx][EW-1:8] == {bus.vid_bank, bus.vaddr})) begin
            snoop_hit = 1'b1;
            snoop_dat = fifo_mem[snoop_idx][7:0];
         end
      end
   end
`endif

   // FIFO storage needs no reset: count decides which entries are live.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {bus.cpu_bank, bus.cpu_addr, bus.cpu_wdata};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rd_addr       <= '0;
         v_p1          <= 1'b0;
         bus.vdata     <= 8'h00;
         bus.vvalid    <= 1'b0;
         bus.cpu_rdata <= 8'h00;
         bus.cpu_ack   <= 1'b0;
`ifdef VRAM_SNOOP_EN
         snoop_hit_q   <= 1'b0;
         snoop_dat_q   <= 8'h00;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         // ULA pipe: address in c, RAM data in c+1, registered result in c+2.
         v_p1       <= bus.vreq;
         bus.vvalid <= v_p1;
`ifdef VRAM_SNOOP_EN
         snoop_hit_q <= snoop_hit & bus.vreq;
         snoop_dat_q <= snoop_dat;
         if (v_p1) bus.vdata <= snoop_hit_q ? snoop_dat_q : bus.mem_rdata;
`else
         if (v_p1) bus.vdata <= bus.mem_rdata;
`endif

         bus.cpu_ack <= push;
         case (state)
            IDLE: begin
               if (bus.cpu_req & ~bus.cpu_we & fifo_empty & ~bus.cpu_ack) begin
                  state   <= RD_ISSUE;
                  rd_addr <= {bus.cpu_bank, bus.cpu_addr};
               end
            end
            RD_ISSUE: begin
               if (~bus.vreq) state <= RD_WAIT;
            end
            RD_WAIT: begin
               bus.cpu_rdata <= bus.mem_rdata;
               bus.cpu_ack   <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
